// File: rtl/io_led_pkg.sv
// Shared register-map constants for the io_led_pwm LED controller.
// Word offsets and CTRL bit positions are used by the RTL; the bench keeps its own copies.
package io_led_pkg;

  localparam int ADR_ON    = 0;
  localparam int ADR_CTRL  = 1;
  localparam int ADR_DUTY0 = 2;

  localparam int PWM_EN    = 0;
  localparam int BLINK_EN  = 1;
  localparam int BLINK_LSB = 8;
  localparam int BLINK_W   = 16;

  function automatic int max_num_led();
    return 8;
  endfunction

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: DUTY register, period-aligned duty shadow, compare and output flop.
// The shadow copy only reloads on the PWM wrap, so a new duty never cuts a period short.
module led_pwm_ch #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_i,
  input  logic [PWM_BITS-1:0] wmask_i,
  input  logic [PWM_BITS-1:0] wdata_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wrap_i,
  input  logic                pwm_en_i,
  input  logic                gate_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                led_o
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] act_q, act_d;
  logic                led_q, led_d;

  always_comb begin
    duty_d = duty_q;
    act_d  = act_q;
    led_d  = 1'b0;
    if (wr_i) begin
      duty_d = (duty_q & ~wmask_i) | (wdata_i & wmask_i);
    end
    // A write landing on the wrap cycle is not yet visible here; it loads next period.
    if (wrap_i) begin
      act_d = duty_q;
    end
    led_d = gate_i & (pwm_en_i ? (pwm_cnt_i < act_q) : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      act_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      act_q  <= act_d;
      led_q  <= led_d;
    end
  end

  assign duty_o = duty_q;
  assign led_o  = led_q;

endmodule

// File: rtl/io_led_pwm.sv
// Memory-mapped LED controller: ON/CTRL registers, shared prescaler and PWM counter,
// global blink generator, registered readback, and one led_pwm_ch per LED.
module io_led_pwm
  import io_led_pkg::*;
#(
  parameter int NUM_LED   = 3,
  parameter int PWM_BITS  = 8,
  parameter int PRESC_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         st_we_io,
  input  logic [11:2]        st_adr_io,
  input  logic [31:0]        st_data_io,
  input  logic               ld_re_io,
  input  logic [11:2]        ld_adr_io,
  output logic [31:0]        ld_data_io,
  output logic [NUM_LED-1:0] led_out
);

  if (NUM_LED < 1 || NUM_LED > max_num_led()) begin : g_bad_num_led
    $error("io_led_pwm: NUM_LED out of range");
  end

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  // Bus: a store happens in any cycle with a nonzero st_we_io (no backpressure);
  // a load is requested by ld_re_io and its data appears on ld_data_io the next
  // cycle, then holds until the next load request.
  logic [31:0] wmask;
  logic        any_we, on_wr, ctrl_wr, ctrl_lane0_wr;
  logic        unused_ok;

  assign wmask  = {{8{st_we_io[3]}}, {8{st_we_io[2]}}, {8{st_we_io[1]}}, {8{st_we_io[0]}}};
  assign any_we = |st_we_io;
  assign on_wr  = any_we && (st_adr_io == 10'(ADR_ON));
  assign ctrl_wr = any_we && (st_adr_io == 10'(ADR_CTRL));
  assign ctrl_lane0_wr = ctrl_wr && st_we_io[0];
  assign unused_ok = ^{st_data_io, wmask};

  logic [NUM_LED-1:0]  on_q, on_d;
  logic                pwm_en_q, pwm_en_d;
  logic                blink_en_q, blink_en_d;
  logic [BLINK_W-1:0]  half_q, half_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [31:0]         ld_data_q, ld_data_d;
  logic                tick, wrap;

  assign tick = (presc_q == PRESC_MAX);
  assign wrap = tick && (pwm_cnt_q == '1);

  always_comb begin
    on_d        = on_q;
    pwm_en_d    = pwm_en_q;
    blink_en_d  = blink_en_q;
    half_d      = half_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (on_wr) begin
      on_d = (on_q & ~wmask[NUM_LED-1:0]) | (st_data_io[NUM_LED-1:0] & wmask[NUM_LED-1:0]);
    end
    if (ctrl_lane0_wr) begin
      pwm_en_d   = st_data_io[PWM_EN];
      blink_en_d = st_data_io[BLINK_EN];
    end
    if (ctrl_wr) begin
      half_d = (half_q & ~wmask[BLINK_LSB +: BLINK_W]) |
               (st_data_io[BLINK_LSB +: BLINK_W] & wmask[BLINK_LSB +: BLINK_W]);
    end
    // Touching CTRL lane 0 restarts the blink sequence in its lit phase.
    if (ctrl_lane0_wr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (half_q == '0) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (wrap) begin
      if (blink_cnt_q >= half_q - BLINK_W'(1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  logic [PWM_BITS-1:0] duty_w [NUM_LED];
  logic [NUM_LED-1:0]  led_w;

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    logic duty_wr;
    assign duty_wr = any_we && (st_adr_io == 10'(ADR_DUTY0 + i));

    led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (duty_wr),
      .wmask_i  (wmask[PWM_BITS-1:0]),
      .wdata_i  (st_data_io[PWM_BITS-1:0]),
      .pwm_cnt_i(pwm_cnt_q),
      .wrap_i   (wrap),
      .pwm_en_i (pwm_en_q),
      .gate_i   (on_q[i] & (blink_en_q ? phase_q : 1'b1)),
      .duty_o   (duty_w[i]),
      .led_o    (led_w[i])
    );
  end

  // Readback uses current register values, so a same-cycle store is not yet visible.
  always_comb begin
    ld_data_d = ld_data_q;
    if (ld_re_io) begin
      ld_data_d = '0;
      if (ld_adr_io == 10'(ADR_ON)) begin
        ld_data_d[NUM_LED-1:0] = on_q;
      end else if (ld_adr_io == 10'(ADR_CTRL)) begin
        ld_data_d[PWM_EN]                = pwm_en_q;
        ld_data_d[BLINK_EN]              = blink_en_q;
        ld_data_d[BLINK_LSB +: BLINK_W]  = half_q;
      end
      for (int i = 0; i < NUM_LED; i++) begin
        if (ld_adr_io == 10'(ADR_DUTY0 + i)) begin
          ld_data_d[PWM_BITS-1:0] = duty_w[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_q        <= '0;
      pwm_en_q    <= 1'b0;
      blink_en_q  <= 1'b0;
      half_q      <= '0;
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      ld_data_q   <= '0;
    end else begin
      on_q        <= on_d;
      pwm_en_q    <= pwm_en_d;
      blink_en_q  <= blink_en_d;
      half_q      <= half_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      ld_data_q   <= ld_data_d;
    end
  end

  assign ld_data_io = ld_data_q;
  assign led_out    = led_w;

endmodule

// File: tb/tb_io_led_pwm.sv
// Directed bench for io_led_pwm (NUM_LED=3, PWM_BITS=8, PRESC_DIV=1).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_io_led_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  st_we_io = '0;
  logic [9:0]  st_adr_io = '0;
  logic [31:0] st_data_io = '0;
  logic        ld_re_io = 1'b0;
  logic [9:0]  ld_adr_io = '0;
  logic [31:0] ld_data_io;
  logic [2:0]  led_out;

  int errors = 0;
  int checks = 0;

  io_led_pwm #(.NUM_LED(3), .PWM_BITS(8), .PRESC_DIV(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_we_io  (st_we_io),
    .st_adr_io (st_adr_io),
    .st_data_io(st_data_io),
    .ld_re_io  (ld_re_io),
    .ld_adr_io (ld_adr_io),
    .ld_data_io(ld_data_io),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [9:0] adr, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    st_adr_io = adr; st_data_io = data; st_we_io = we;
    @(negedge clk);
    st_we_io = 4'b0000;
  endtask

  task automatic bus_read(input logic [9:0] adr, output logic [31:0] data);
    @(negedge clk);
    ld_adr_io = adr; ld_re_io = 1'b1;
    @(negedge clk);
    ld_re_io = 1'b0;
    data = ld_data_io;
  endtask

  // Leaves the bench on the first high sample of a led_out[0] pulse (period start).
  task automatic wait_rise(input int bound, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = led_out[0];
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (!prev && led_out[0]) begin
        ok = 1'b1;
        return;
      end
      prev = led_out[0];
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_out !== 3'b000) begin
      errors++; $display("FAIL reset_led: got %b want 000", led_out);
    end
    checks++;
    if (ld_data_io !== 32'h0) begin
      errors++; $display("FAIL reset_ld: got %h want 00000000", ld_data_io);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_legacy();
    logic [31:0] rd;
    int bad;
    bus_write(10'd0, 32'h5, 4'b0001);
    checks++;
    if (led_out !== 3'b000) begin
      errors++; $display("FAIL legacy_latency1: got %b want 000", led_out);
    end
    @(negedge clk);
    checks++;
    if (led_out !== 3'b101) begin
      errors++; $display("FAIL legacy_latency2: got %b want 101", led_out);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (led_out !== 3'b101) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL legacy_steady: %0d samples differ from 101, want 0", bad);
    end
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++; $display("FAIL legacy_read: got %h want 00000005", rd);
    end
  endtask

  task automatic test_read_hold();
    repeat (3) @(negedge clk);
    ld_adr_io = 10'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (ld_data_io !== 32'h5) begin
      errors++; $display("FAIL read_hold: got %h want 00000005", ld_data_io);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    bus_write(10'd0, 32'h2, 4'b0000);
    bus_write(10'd40, 32'hFFFF_FFFF, 4'b1111);
    bus_write(10'd5, 32'hFFFF_FFFF, 4'b1111);
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++; $display("FAIL no_we_write: got %h want 00000005", rd);
    end
    bus_read(10'd40, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL unmapped40_read: got %h want 00000000", rd);
    end
    bus_read(10'd5, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL unmapped5_read: got %h want 00000000", rd);
    end
    bus_read(10'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL ctrl_untouched: got %h want 00000000", rd);
    end
    bus_write(10'd0, 32'hFFFF_FFFF, 4'b1111);
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'h7) begin
      errors++; $display("FAIL on_upper_bits: got %h want 00000007", rd);
    end
    bus_write(10'd0, 32'h5, 4'b0001);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic [31:0] want [4];
    logic [3:0]  lane [4];
    want[0] = 32'h0000_FF00; lane[0] = 4'b0010;
    want[1] = 32'h00FF_FF00; lane[1] = 4'b0100;
    want[2] = 32'h00FF_FF00; lane[2] = 4'b1000;
    want[3] = 32'h00FF_FF03; lane[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus_write(10'd1, 32'hFFFF_FFFF, lane[k]);
      bus_read(10'd1, rd);
      checks++;
      if (rd !== want[k]) begin
        errors++; $display("FAIL ctrl_lane%0d: got %h want %h", k, rd, want[k]);
      end
    end
    bus_write(10'd1, 32'h0, 4'b1111);
    bus_read(10'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL ctrl_clear: got %h want 00000000", rd);
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] rd;
    @(negedge clk);
    st_adr_io = 10'd0; st_data_io = 32'h3; st_we_io = 4'b0001;
    ld_adr_io = 10'd0; ld_re_io = 1'b1;
    @(negedge clk);
    st_we_io = 4'b0000; ld_re_io = 1'b0;
    checks++;
    if (ld_data_io !== 32'h5) begin
      errors++; $display("FAIL same_addr_old: got %h want 00000005", ld_data_io);
    end
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++; $display("FAIL same_addr_new: got %h want 00000003", rd);
    end
  endtask

  task automatic test_pwm_duty();
    int hi [3];
    int want [3];
    logic [31:0] rd;
    want[0] = 64; want[1] = 0; want[2] = 255;
    bus_write(10'd0, 32'h7, 4'b0001);
    bus_write(10'd2, 32'd64, 4'b0001);
    bus_write(10'd3, 32'd0, 4'b0001);
    bus_write(10'd4, 32'd255, 4'b0001);
    bus_write(10'd1, 32'h1, 4'b0001);
    repeat (260) @(negedge clk);
    for (int c = 0; c < 3; c++) hi[c] = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (led_out[c]) hi[c]++;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (hi[c] != want[c]) begin
        errors++; $display("FAIL pwm_ch%0d_high: got %0d want %0d", c, hi[c], want[c]);
      end
    end
    bus_read(10'd4, rd);
    checks++;
    if (rd !== 32'd255) begin
      errors++; $display("FAIL duty2_read: got %h want 000000ff", rd);
    end
  endtask

  task automatic test_duty_shadow();
    bit ok;
    int hi [2];
    logic [31:0] rd;
    wait_rise(600, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL shadow_sync: got no rise want rise within 600 cycles");
      return;
    end
    hi[0] = 0; hi[1] = 0;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) @(negedge clk);
      if (led_out[0]) hi[k / 256]++;
      if (k == 10) begin
        st_adr_io = 10'd2; st_data_io = 32'd200; st_we_io = 4'b0001;
      end else begin
        st_we_io = 4'b0000;
      end
    end
    checks++;
    if (hi[0] != 64) begin
      errors++; $display("FAIL shadow_cur_period: got %0d want 64", hi[0]);
    end
    checks++;
    if (hi[1] != 200) begin
      errors++; $display("FAIL shadow_next_period: got %0d want 200", hi[1]);
    end
    bus_read(10'd2, rd);
    checks++;
    if (rd !== 32'd200) begin
      errors++; $display("FAIL duty0_read: got %h want 000000c8", rd);
    end
  endtask

  task automatic test_blink();
    bit ok;
    int win [7];
    int want [7];
    want[0] = 128; want[1] = 128; want[2] = 0; want[3] = 0;
    want[4] = 128; want[5] = 128; want[6] = 0;
    bus_write(10'd2, 32'd128, 4'b0001);
    repeat (300) @(negedge clk);
    wait_rise(600, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL blink_sync: got no rise want rise within 600 cycles");
      return;
    end
    for (int w = 0; w < 7; w++) win[w] = 0;
    for (int k = 0; k < 7 * 256; k++) begin
      if (k > 0) @(negedge clk);
      if (led_out[0]) win[k / 256]++;
      if (k == 10) begin
        st_adr_io = 10'd1; st_data_io = 32'h0000_0203; st_we_io = 4'b1111;
      end else begin
        st_we_io = 4'b0000;
      end
    end
    for (int w = 0; w < 7; w++) begin
      checks++;
      if (win[w] != want[w]) begin
        errors++; $display("FAIL blink_period%0d: got %0d want %0d", w, win[w], want[w]);
      end
    end
  endtask

  task automatic test_reset_async();
    bit ok;
    logic [31:0] rd;
    int bad;
    bus_read(10'd1, rd);
    wait_rise(1200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_sync: got no rise want rise within 1200 cycles");
    end
    repeat (5) @(negedge clk);
    checks++;
    if (led_out[0] !== 1'b1) begin
      errors++; $display("FAIL rst_pre_led: got %b want 1", led_out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 3'b000 || ld_data_io !== 32'h0) begin
      errors++; $display("FAIL rst_async: got led=%b ld=%h want 000/00000000", led_out, ld_data_io);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus_read(10'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL rst_reg%0d: got %h want 00000000", a, rd);
      end
    end
    bus_write(10'd0, 32'h1, 4'b0001);
    bus_write(10'd1, 32'h2, 4'b0001);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (led_out !== 3'b001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL blink_half0_lit: %0d samples differ from 001, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_read_hold();
    test_unmapped();
    test_byte_lanes();
    test_same_addr();
    test_pwm_duty();
    test_duty_shadow();
    test_blink();
    test_reset_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
